// File: rtl/input_mapper_pkg.sv
// Shared input-index constants, keymap entry type and power-on keymap
// for the PS/2 + joystick input mapper.
package input_mapper_pkg;

  localparam int IDX_RIGHT = 0;
  localparam int IDX_LEFT  = 1;
  localparam int IDX_DOWN  = 2;
  localparam int IDX_UP    = 3;
  localparam int IDX_BTN0  = 4;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  function automatic int idx_start(int nb);
    return nb + 4;
  endfunction

  function automatic int idx_coin(int nb);
    return nb + 5;
  endfunction

  function automatic int idx_pause(int nb);
    return nb + 6;
  endfunction

  function automatic logic [7:0] btn_code(int p, int b);
    logic [7:0] c;
    c = 8'h00;
    case (b)
      0: c = (p == 0) ? 8'h14 : 8'h1C;
      1: c = (p == 0) ? 8'h11 : 8'h1B;
      2: c = (p == 0) ? 8'h29 : 8'h15;
      3: c = (p == 0) ? 8'h12 : 8'h1D;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic key_entry_t reset_entry(int p, int i, int nb);
    key_entry_t e;
    e = '0;
    if (p == 0) begin
      if (i == IDX_UP)              e.code = 8'h75;
      else if (i == IDX_DOWN)       e.code = 8'h72;
      else if (i == IDX_LEFT)       e.code = 8'h6B;
      else if (i == IDX_RIGHT)      e.code = 8'h74;
      else if (i == idx_start(nb))  e.code = 8'h16;
      else if (i == idx_coin(nb))   e.code = 8'h2E;
      else if (i == idx_pause(nb))  e.code = 8'h4D;
      else if (i >= IDX_BTN0)       e.code = btn_code(0, i - IDX_BTN0);
    end else if (p == 1) begin
      if (i == IDX_UP)              e.code = 8'h2D;
      else if (i == IDX_DOWN)       e.code = 8'h2B;
      else if (i == IDX_LEFT)       e.code = 8'h23;
      else if (i == IDX_RIGHT)      e.code = 8'h34;
      else if (i == idx_start(nb))  e.code = 8'h1E;
      else if (i == idx_coin(nb))   e.code = 8'h36;
      else if (i == idx_pause(nb))  e.code = 8'h00;
      else if (i >= IDX_BTN0)       e.code = btn_code(1, i - IDX_BTN0);
    end
    return e;
  endfunction

endpackage

// File: rtl/input_mapper_coin_stretcher.sv
// Coin pulse stretcher: holds coin high for HOLD cycles after a rising edge.
module coin_stretcher #(
  parameter int HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_i,
  output logic coin_o
);

  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (coin_i && !prev_q) cnt_d = CW'(HOLD);
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= coin_i;
    end
  end

  assign coin_o = coin_i | (cnt_q != '0);

endmodule

// File: rtl/input_mapper.sv
// PS/2 keyboard + joystick to per-player arcade controls.
// Define INPUT_MAPPER_AUTOFIRE_EN to enable masked button autofire.
module input_mapper
  import input_mapper_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BUTTONS  = 4,
  parameter int COIN_HOLD    = 16,
  parameter int AUTOFIRE_DIV = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [10:0]                         ps2_key,
  input  logic [32*NUM_PLAYERS-1:0]           joystick_i,
  input  logic                                map_wr,
  input  logic [5:0]                          map_addr,
  input  logic [8:0]                          map_code,
  input  logic                                clear,
  input  logic [NUM_BUTTONS*NUM_PLAYERS-1:0]  autofire_mask,
  output logic [(NUM_BUTTONS+7)*NUM_PLAYERS-1:0] inputs_o
);

  localparam int NI = NUM_BUTTONS + 7;
  localparam int OW = NI * NUM_PLAYERS;

  logic       tog_q;
  logic       key_evt;
  key_entry_t evt_key;
  logic [OW-1:0] key_st, raw, out_d, out_q;
  logic [NUM_PLAYERS-1:0] coin_out;
  logic phase;
  logic unused_ok;

  assign key_evt = ps2_key[10] ^ tog_q;
  assign evt_key = key_entry_t'(ps2_key[8:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q <= 1'b0;
      out_q <= '0;
    end else begin
      tog_q <= ps2_key[10];
      out_q <= out_d;
    end
  end

`ifdef INPUT_MAPPER_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_DIV);
  logic [AW-1:0] af_q;
  logic          phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q    <= '0;
      phase_q <= 1'b0;
    end else if (af_q == AW'(AUTOFIRE_DIV - 1)) begin
      af_q    <= '0;
      phase_q <= ~phase_q;
    end else begin
      af_q <= af_q + AW'(1);
    end
  end

  assign phase     = phase_q;
  assign unused_ok = ^joystick_i;
`else
  assign phase     = 1'b1;
  assign unused_ok = ^{joystick_i, autofire_mask};
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    for (genvar i = 0; i < NI; i++) begin : g_in
      localparam int E = p * NI + i;
      key_entry_t map_q;
      logic       key_q, key_d;
      logic       hit_wr, hit_ev;

      assign hit_wr = map_wr && (map_addr == 6'(p * 16 + i));
      assign hit_ev = key_evt && (map_q != '0) && (map_q == evt_key);

      // Clear and remap both beat a coincident key event.
      always_comb begin
        key_d = key_q;
        if (hit_ev) key_d = ps2_key[9];
        if (hit_wr || clear) key_d = 1'b0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          map_q <= reset_entry(p, i, NUM_BUTTONS);
          key_q <= 1'b0;
        end else begin
          if (hit_wr) map_q <= key_entry_t'(map_code);
          key_q <= key_d;
        end
      end

      assign key_st[E] = key_q;
      assign raw[E]    = key_q | joystick_i[32*p+i];

      if (i == NUM_BUTTONS + 5) begin : g_coin
        assign out_d[E] = coin_out[p];
      end else if (i >= IDX_BTN0 && i < IDX_BTN0 + NUM_BUTTONS) begin : g_btn
        localparam int M = p * NUM_BUTTONS + i - IDX_BTN0;
        assign out_d[E] = raw[E] & (~autofire_mask[M] | phase);
      end else begin : g_plain
        assign out_d[E] = raw[E];
      end
    end

    coin_stretcher #(.HOLD(COIN_HOLD)) u_coin (
      .clk   (clk),
      .rst   (rst),
      .coin_i(raw[p*NI+NUM_BUTTONS+5]),
      .coin_o(coin_out[p])
    );
  end

  assign inputs_o = out_q;

endmodule

// File: tb/tb_input_mapper.sv
// Self-checking bench for input_mapper against an edge-counting reference model.
module tb_input_mapper;

  localparam int NP   = 2;
  localparam int NB   = 4;
  localparam int NI   = NB + 7;
  localparam int OW   = NI * NP;
  localparam int HOLD = 16;
  localparam int DIV  = 4;
  localparam int COIN = NB + 5;

  localparam logic [7:0] P0 [NI] = '{8'h74, 8'h6B, 8'h72, 8'h75,
    8'h14, 8'h11, 8'h29, 8'h12, 8'h16, 8'h2E, 8'h4D};
  localparam logic [7:0] P1 [NI] = '{8'h34, 8'h23, 8'h2B, 8'h2D,
    8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h1E, 8'h36, 8'h00};

  logic clk = 1'b0;
  logic rst;
  logic [10:0] ps2_key;
  logic [32*NP-1:0] joy;
  logic map_wr;
  logic [5:0] map_addr;
  logic [8:0] map_code;
  logic clear;
  logic [NB*NP-1:0] af_mask;
  logic [OW-1:0] inputs_o;

  always #5 clk = ~clk;

  input_mapper #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB),
    .COIN_HOLD(HOLD), .AUTOFIRE_DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joystick_i(joy),
    .map_wr(map_wr), .map_addr(map_addr), .map_code(map_code),
    .clear(clear), .autofire_mask(af_mask), .inputs_o(inputs_o)
  );

  int vectors = 0;
  int errors  = 0;

  logic [8:0] m_map [NP][NI];
  bit m_ks [NP][NI];
  bit m_tog;
  bit m_cprev [NP];
  int m_rise [NP];
  int m_edge;
  logic [OW-1:0] exp_out;

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_map[0][i] = {1'b0, P0[i]};
      m_map[1][i] = {1'b0, P1[i]};
      m_ks[0][i] = 0;
      m_ks[1][i] = 0;
    end
    m_tog = 0;
    for (int p = 0; p < NP; p++) begin
      m_cprev[p] = 0;
      m_rise[p] = -1000;
    end
    m_edge = 0;
    exp_out = '0;
  endfunction

  task automatic step();
    int k;
    bit r, b, evt;
    k = m_edge + 1;
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < NI; i++) begin
        r = m_ks[p][i] | joy[32*p+i];
        b = r;
        if (i == COIN) begin
          b = r || (k - m_rise[p] >= 1 && k - m_rise[p] <= HOLD);
          if (r && !m_cprev[p]) m_rise[p] = k;
          m_cprev[p] = r;
        end
`ifdef INPUT_MAPPER_AUTOFIRE_EN
        if (i >= 4 && i < 4 + NB && af_mask[p*NB+i-4] && ((k - 1) / DIV) % 2 == 0)
          b = 0;
`endif
        exp_out[p*NI+i] = b;
      end
    end
    evt = ps2_key[10] != m_tog;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < NI; i++)
        if (evt && m_map[p][i] != 0 && m_map[p][i] == ps2_key[8:0])
          m_ks[p][i] = ps2_key[9];
    if (map_wr && int'(map_addr[5:4]) < NP && int'(map_addr[3:0]) < NI) begin
      m_map[map_addr[5:4]][map_addr[3:0]] = map_code;
      m_ks[map_addr[5:4]][map_addr[3:0]] = 0;
    end
    if (clear)
      for (int p = 0; p < NP; p++)
        for (int i = 0; i < NI; i++) m_ks[p][i] = 0;
    m_tog = ps2_key[10];
    m_edge = k;
    @(posedge clk);
    #1;
  endtask

  task automatic key_ev(bit pressed, bit ext, logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ps2_key = '0; joy = '0; map_wr = 0; map_addr = '0;
    map_code = '0; clear = 0; af_mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (inputs_o !== '0) begin
      errors++;
      $display("FAIL reset: got %h expected 0", inputs_o);
    end
    rst = 1'b0;
    repeat (3) begin
      step();
      vectors++;
      if (inputs_o !== exp_out) begin
        errors++;
        $display("FAIL idle: got %h expected %h", inputs_o, exp_out);
      end
    end
  endtask

  task automatic test_key_latency();
    key_ev(1, 0, 8'h75);
    step();
    vectors++;
    if (inputs_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL up_edge1: got %b expected 0", inputs_o[3]);
    end
    step();
    vectors++;
    if (inputs_o[3] !== 1'b1 || inputs_o !== exp_out) begin
      errors++;
      $display("FAIL up_press: got %h expected %h", inputs_o, exp_out);
    end
    key_ev(0, 0, 8'h75);
    step(); step();
    vectors++;
    if (inputs_o[3] !== 1'b0 || inputs_o !== exp_out) begin
      errors++;
      $display("FAIL up_release: got %h expected %h", inputs_o, exp_out);
    end
  endtask

  task automatic test_joystick();
    for (int n = 0; n < 40; n++) begin
      joy = {$urandom, $urandom} & {$urandom, $urandom};
      step();
      vectors++;
      if (inputs_o !== exp_out) begin
        errors++;
        $display("FAIL joystick: got %h expected %h", inputs_o, exp_out);
      end
    end
    joy = '0;
    repeat (HOLD + 2) step();
  endtask

  task automatic test_coin();
    int cnt;
    joy[COIN] = 1'b1;
    step();
    joy[COIN] = 1'b0;
    cnt = int'(inputs_o[COIN]);
    for (int n = 0; n < 24; n++) begin
      step();
      cnt += int'(inputs_o[COIN]);
      vectors++;
      if (inputs_o !== exp_out) begin
        errors++;
        $display("FAIL coin_model: got %h expected %h", inputs_o, exp_out);
      end
    end
    vectors++;
    if (cnt != HOLD + 1) begin
      errors++;
      $display("FAIL coin_len: got %0d expected %0d", cnt, HOLD + 1);
    end
  endtask

  task automatic test_remap();
    map_wr = 1; map_addr = 6'h04; map_code = 9'h01A;
    step();
    map_addr = 6'h0B; map_code = 9'h075;
    step();
    map_addr = 6'h13; map_code = 9'h075;
    step();
    map_wr = 0;
    key_ev(1, 0, 8'h1A);
    step(); step();
    vectors++;
    if (inputs_o[4] !== 1'b1 || inputs_o !== exp_out) begin
      errors++;
      $display("FAIL remap_press: got %h expected %h", inputs_o, exp_out);
    end
    key_ev(0, 0, 8'h1A);
    step(); step();
    key_ev(1, 0, 8'h14);
    step(); step();
    vectors++;
    if (inputs_o[4] !== 1'b0 || inputs_o !== exp_out) begin
      errors++;
      $display("FAIL old_code: got %h expected %h", inputs_o, exp_out);
    end
    key_ev(1, 0, 8'h75);
    step(); step();
    vectors++;
    if (inputs_o[3] !== 1'b1 || inputs_o[NI+3] !== 1'b1) begin
      errors++;
      $display("FAIL multi_match: got %h expected %h", inputs_o, exp_out);
    end
    key_ev(0, 0, 8'h75);
    step(); step();
    vectors++;
    if (inputs_o !== exp_out) begin
      errors++;
      $display("FAIL multi_release: got %h expected %h", inputs_o, exp_out);
    end
  endtask

  task automatic test_same_cycle();
    map_wr = 1; map_addr = 6'h03; map_code = 9'h075;
    key_ev(1, 0, 8'h75);
    step();
    map_wr = 0;
    step(); step();
    vectors++;
    if (inputs_o[3] !== 1'b0 || inputs_o !== exp_out) begin
      errors++;
      $display("FAIL wr_vs_event: got %h expected %h", inputs_o, exp_out);
    end
    key_ev(0, 0, 8'h75);
    step();
  endtask

  task automatic test_clear();
    key_ev(1, 0, 8'h75);
    step(); step();
    vectors++;
    if (inputs_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre: got %b expected 1", inputs_o[3]);
    end
    clear = 1;
    step();
    clear = 0;
    step();
    vectors++;
    if (inputs_o[3] !== 1'b0 || inputs_o !== exp_out) begin
      errors++;
      $display("FAIL clear: got %h expected %h", inputs_o, exp_out);
    end
    key_ev(0, 0, 8'h75);
    step();
  endtask

  task automatic test_autofire();
    bit prev;
    int run, first;
    af_mask = '0;
    af_mask[0] = 1'b1;
    joy[4] = 1'b1;
    step();
    prev = inputs_o[4];
    run = 1; first = 1;
    for (int n = 0; n < 24; n++) begin
      step();
      vectors++;
      if (inputs_o !== exp_out) begin
        errors++;
        $display("FAIL af_model: got %h expected %h", inputs_o, exp_out);
      end
`ifdef INPUT_MAPPER_AUTOFIRE_EN
      if (inputs_o[4] != prev) begin
        vectors++;
        if (!first && run != DIV) begin
          errors++;
          $display("FAIL af_run: got %0d expected %0d", run, DIV);
        end
        first = 0; run = 1; prev = inputs_o[4];
      end else begin
        run++;
      end
`else
      vectors++;
      if (inputs_o[4] !== 1'b1) begin
        errors++;
        $display("FAIL af_off: got %b expected 1", inputs_o[4]);
      end
`endif
    end
    joy[4] = 1'b0;
    af_mask = '0;
    step();
  endtask

  task automatic test_random();
    logic [7:0] codes [6];
    codes = '{8'h75, 8'h14, 8'h2E, 8'h36, 8'h1C, 8'h5A};
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(2) == 0)
        key_ev(1'($urandom), 1'($urandom_range(7) == 0),
               codes[$urandom_range(5)]);
      joy = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      map_wr = ($urandom_range(19) == 0);
      map_addr = 6'($urandom);
      map_code = {1'b0, codes[$urandom_range(5)]};
      clear = ($urandom_range(29) == 0);
      if ($urandom_range(15) == 0) af_mask = NB*NP'($urandom);
      step();
      vectors++;
      if (inputs_o !== exp_out) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", n, inputs_o, exp_out);
      end
    end
    map_wr = 0; clear = 0; joy = '0; af_mask = '0;
  endtask

  task automatic test_rst_mid();
    joy[COIN] = 1'b1;
    step();
    joy[COIN] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (inputs_o !== '0) begin
      errors++;
      $display("FAIL rst_mid: got %h expected 0", inputs_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      step();
      vectors++;
      if (inputs_o !== exp_out) begin
        errors++;
        $display("FAIL post_rst: got %h expected %h", inputs_o, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_latency();
    test_joystick();
    test_coin();
    test_remap();
    test_same_cycle();
    test_clear();
    test_autofire();
    test_random();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
